// File: rtl/memoria_pipe.sv
// Word-addressed RAM with per-byte write enables, a configurable read pipeline and
// a power-up clear sequence that zeroes every word before requests are accepted.
module memoria_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_enable,
    input  logic                    mem_op,
    input  logic [31:0]             MAR,
    input  logic [DATA_WIDTH-1:0]   MBR_out,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   MBR_in,
    output logic                    rd_valid,
    output logic                    mem_ready,
    output logic                    addr_err
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    clearing_c;
    logic                    clr_last_c;
    logic [AW-1:0]           clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic                    accept_c;
    logic                    in_range_c;
    logic [AW-1:0]           idx_c;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    assign accept_c   = mem_enable & mem_ready;
    assign in_range_c = (MAR < 32'(MEM_WORDS));
    assign idx_c      = MAR[AW-1:0];
    assign clr_last_c = (clr_cnt == AW'(MEM_WORDS - 1));

    // State register; mem_ready is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            mem_ready <= 1'b0;
        end else begin
            state     <= state_next;
            mem_ready <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clr_last_c) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        clearing_c = 1'b0;
        case (state)
            INIT:    clearing_c = 1'b1;
            default: clearing_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (clearing_c) begin
            clr_cnt <= clr_last_c ? '0 : clr_cnt + AW'(1);
        end
    end

    // Array port: clear sweep during INIT, masked byte writes during RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clearing_c) begin
                mem[clr_cnt] <= '0;
            end else if (accept_c && mem_op && in_range_c) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_en[b]) mem[idx_c][8*b +: 8] <= MBR_out[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (accept_c && !in_range_c) begin
            addr_err <= 1'b1;
        end
    end

    // Stage 0 samples the array at the accept edge; MBR_in is the register after the last stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
            MBR_in   <= '0;
            rd_valid <= 1'b0;
        end else begin
            pipe_vld[0] <= accept_c & ~mem_op;
            if (accept_c && !mem_op) pipe_data[0] <= in_range_c ? mem[idx_c] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            rd_valid <= pipe_vld[READ_LATENCY-1];
            if (pipe_vld[READ_LATENCY-1]) MBR_in <= pipe_data[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_memoria_pipe.sv
// Directed bench: two instances (read latency 1 and 3) share one stimulus stream,
// each scenario task checks both against hand-computed timing and data.
module tb_memoria_pipe;

    logic        clock;
    logic        reset;
    logic        mem_enable;
    logic        mem_op;
    logic [31:0] MAR;
    logic [31:0] MBR_out;
    logic [3:0]  byte_en;
    logic [31:0] mbr1, mbr3;
    logic        rv1, rv3, rdy1, rdy3, err1, err3;

    int checks = 0;
    int errors = 0;

    memoria_pipe #(.DATA_WIDTH(32), .MEM_WORDS(16), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .mem_enable(mem_enable), .mem_op(mem_op),
        .MAR(MAR), .MBR_out(MBR_out), .byte_en(byte_en),
        .MBR_in(mbr1), .rd_valid(rv1), .mem_ready(rdy1), .addr_err(err1)
    );

    memoria_pipe #(.DATA_WIDTH(32), .MEM_WORDS(16), .READ_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .mem_enable(mem_enable), .mem_op(mem_op),
        .MAR(MAR), .MBR_out(MBR_out), .byte_en(byte_en),
        .MBR_in(mbr3), .rd_valid(rv3), .mem_ready(rdy3), .addr_err(err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        mem_enable = en;
        mem_op     = op;
        MAR        = addr;
        MBR_out    = data;
        byte_en    = be;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step();
        step();
        checks++;
        if ({rv1, rdy1, err1} !== 3'b000 || mbr1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_dut1: rv/rdy/err=%b mbr=%h, required 000 and 0", {rv1, rdy1, err1}, mbr1);
        end
        checks++;
        if ({rv3, rdy3, err3} !== 3'b000 || mbr3 !== 32'd0) begin
            errors++;
            $display("FAIL reset_dut3: rv/rdy/err=%b mbr=%h, required 000 and 0", {rv3, rdy3, err3}, mbr3);
        end
    endtask

    // Clear sequence timing, with writes presented while not ready (must be ignored).
    task automatic test_init(input string tag);
        logic exp_rdy;
        drive(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'hF);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i % 4 == 0) drive(1'b1, 1'b0, 32'd20, 32'd0, 4'hF);
            else            drive(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'hF);
            step();
            exp_rdy = (i == 16);
            checks++;
            if (rdy1 !== exp_rdy || rdy3 !== exp_rdy) begin
                errors++;
                $display("FAIL %s_ready cycle %0d: rdy1=%b rdy3=%b, required %b", tag, i, rdy1, rdy3, exp_rdy);
            end
            checks++;
            if ({rv1, rv3, err1, err3} !== 4'b0000) begin
                errors++;
                $display("FAIL %s_ignored cycle %0d: rv1 rv3 err1 err3=%b, required 0000", tag, i, {rv1, rv3, err1, err3});
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic test_clear_reads();
        logic e1, e3;
        for (int t = 0; t <= 18; t++) begin
            if (t < 16) drive(1'b1, 1'b0, 32'(t), 32'd0, 4'hF);
            else        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            step();
            e1 = (t >= 1 && t <= 16);
            e3 = (t >= 3 && t <= 18);
            checks++;
            if (rv1 !== e1 || rv3 !== e3 || mbr1 !== 32'd0 || mbr3 !== 32'd0) begin
                errors++;
                $display("FAIL clear_read t=%0d: rv1=%b mbr1=%h rv3=%b mbr3=%h, required rv1=%b rv3=%b data 0",
                         t, rv1, mbr1, rv3, mbr3, e1, e3);
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF);
        step();
        drive(1'b1, 1'b0, 32'd5, 32'd0, 4'h0);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int s = 0; s <= 4; s++) begin
            if (s > 0) step();
            checks++;
            if (rv1 !== (s == 1) || (s >= 1 && mbr1 !== 32'hDEAD_BEEF)) begin
                errors++;
                $display("FAIL raw_dut1 s=%0d: rv=%b mbr=%h, required rv=%b mbr=deadbeef", s, rv1, mbr1, (s == 1));
            end
            checks++;
            if (rv3 !== (s == 3) || (s >= 3 && mbr3 !== 32'hDEAD_BEEF)) begin
                errors++;
                $display("FAIL raw_dut3 s=%0d: rv=%b mbr=%h, required rv=%b mbr=deadbeef", s, rv3, mbr3, (s == 3));
            end
        end
    endtask

    task automatic test_byte_en();
        drive(1'b1, 1'b1, 32'd5, 32'h1122_3344, 4'b0101);
        step();
        drive(1'b1, 1'b1, 32'd5, 32'h0000_0000, 4'b0000);
        step();
        drive(1'b1, 1'b0, 32'd5, 32'h0000_0000, 4'b0000);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step();
        checks++;
        if (rv1 !== 1'b1 || mbr1 !== 32'hDE22_BE44) begin
            errors++;
            $display("FAIL byte_en_dut1: rv=%b mbr=%h, required 1 de22be44", rv1, mbr1);
        end
        step();
        step();
        checks++;
        if (rv3 !== 1'b1 || mbr3 !== 32'hDE22_BE44) begin
            errors++;
            $display("FAIL byte_en_dut3: rv=%b mbr=%h, required 1 de22be44", rv3, mbr3);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'(k + 1), exp_d[k], 4'hF);
            step();
        end
        for (int t = 0; t <= 6; t++) begin
            if (t < 3) drive(1'b1, 1'b0, 32'(t + 1), 32'd0, 4'hF);
            else       drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            step();
            checks++;
            if (rv1 !== (t >= 1 && t <= 3) || (t >= 1 && t <= 3 && mbr1 !== exp_d[t-1])) begin
                errors++;
                $display("FAIL b2b_dut1 t=%0d: rv=%b mbr=%h", t, rv1, mbr1);
            end
            checks++;
            if (rv3 !== (t >= 3 && t <= 5) || (t >= 3 && t <= 5 && mbr3 !== exp_d[t-3])) begin
                errors++;
                $display("FAIL b2b_dut3 t=%0d: rv=%b mbr=%h", t, rv3, mbr3);
            end
        end
    endtask

    task automatic test_addr_err();
        checks++;
        if (err1 !== 1'b0 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_pre: err1=%b err3=%b, required 0", err1, err3);
        end
        drive(1'b1, 1'b0, 32'd16, 32'd0, 4'hF);
        step();
        checks++;
        if (err1 !== 1'b1 || err3 !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_set: err1=%b err3=%b, required 1", err1, err3);
        end
        drive(1'b1, 1'b1, 32'd23, 32'hFFFF_FFFF, 4'hF);
        step();
        checks++;
        if (rv1 !== 1'b1 || mbr1 !== 32'd0) begin
            errors++;
            $display("FAIL oor_read_dut1: rv=%b mbr=%h, required 1 0", rv1, mbr1);
        end
        drive(1'b1, 1'b0, 32'd7, 32'd0, 4'hF);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        step();
        checks++;
        if (rv3 !== 1'b1 || mbr3 !== 32'd0) begin
            errors++;
            $display("FAIL oor_read_dut3: rv=%b mbr=%h, required 1 0", rv3, mbr3);
        end
        checks++;
        if (rv1 !== 1'b1 || mbr1 !== 32'd0) begin
            errors++;
            $display("FAIL oor_write_dut1: rv=%b mbr=%h, required 1 0", rv1, mbr1);
        end
        step();
        step();
        checks++;
        if (rv3 !== 1'b1 || mbr3 !== 32'd0 || err1 !== 1'b1 || err3 !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_dut3: rv=%b mbr=%h err=%b%b, required 1 0 11", rv3, mbr3, err1, err3);
        end
    endtask

    task automatic test_reset_flush();
        drive(1'b1, 1'b0, 32'd1, 32'd0, 4'hF);
        step();
        drive(1'b1, 1'b0, 32'd2, 32'd0, 4'hF);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b1;
        #1;
        checks++;
        if ({rv1, rdy1, err1, rv3, rdy3, err3} !== 6'd0 || mbr1 !== 32'd0 || mbr3 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: flags=%b mbr1=%h mbr3=%h, required all 0",
                     {rv1, rdy1, err1, rv3, rdy3, err3}, mbr1, mbr3);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (rv1 !== 1'b0 || rv3 !== 1'b0) begin
                errors++;
                $display("FAIL flush_in_reset %0d: rv1=%b rv3=%b, required 0", i, rv1, rv3);
            end
        end
        test_init("reinit");
        drive(1'b1, 1'b0, 32'd5, 32'd0, 4'hF);
        step();
        drive(1'b1, 1'b0, 32'd1, 32'd0, 4'hF);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        checks++;
        if (rv1 !== 1'b1 || mbr1 !== 32'd0) begin
            errors++;
            $display("FAIL recleared_dut1: rv=%b mbr=%h, required 1 0", rv1, mbr1);
        end
        step();
        step();
        checks++;
        if (rv3 !== 1'b1 || mbr3 !== 32'd0) begin
            errors++;
            $display("FAIL recleared_dut3: rv=%b mbr=%h, required 1 0", rv3, mbr3);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_clear_reads();
        test_write_read();
        test_byte_en();
        test_back_to_back();
        test_addr_err();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
